// File: rtl/i_mem_b_arbiter.sv
// i_mem_b_arbiter
// Shares port B of the big-core instruction memory between the core fetch
// path and the fabric/loader path. One requester is granted per cycle; the
// grant drives address/data/wren straight to the memory, and the 1-cycle
// synchronous read data is steered back to whichever side owns it.
//
// Build option: define I_MEM_ARB_STARVE_EN to add the starvation counter
// that forces a fabric grant after STARVE_LIMIT blocked cycles. Without it
// the core has strict priority.
//
// Ports:
//   clock, rst_n                 clock, async active-low reset
//   core_req/core_addr           core fetch request (word address)
//   core_gnt                     core request accepted this cycle
//   core_rsp_valid/core_rsp_data core read data, no backpressure
//   f_req_valid/f_req_ready      fabric request handshake
//   f_req_wr/f_req_addr/f_req_data fabric request payload
//   f_rsp_valid/f_rsp_ready      fabric read response handshake
//   f_rsp_data                   fabric read data
//   mem_address_b/mem_data_b/mem_wren_b  memory port B drive
//   mem_q_b                      memory read data, 1 cycle after address
module i_mem_b_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int STARVE_W     = 8
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic [29:0] core_addr,
    output logic        core_gnt,
    output logic        core_rsp_valid,
    output logic [31:0] core_rsp_data,
    input  logic        f_req_valid,
    output logic        f_req_ready,
    input  logic        f_req_wr,
    input  logic [29:0] f_req_addr,
    input  logic [31:0] f_req_data,
    output logic        f_rsp_valid,
    input  logic        f_rsp_ready,
    output logic [31:0] f_rsp_data,
    output logic [29:0] mem_address_b,
    output logic [31:0] mem_data_b,
    output logic        mem_wren_b,
    input  logic [31:0] mem_q_b
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || STARVE_LIMIT >= (1 << STARVE_W)) begin : g_bad_param
        $error("i_mem_b_arbiter: STARVE_LIMIT out of range for STARVE_W");
    end

    logic        own_core_q, own_core_d;
    logic        own_fab_q, own_fab_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_q, hold_d;
    logic        fab_elig, fab_win, starve_force;

    // A fabric read may only go out when nothing of its own is in flight or
    // parked, so at most one fabric read response is ever outstanding.
    // Writes produce no response and are always eligible.
    assign fab_elig = f_req_valid & (f_req_wr | ~(own_fab_q | hold_v_q));

`ifdef I_MEM_ARB_STARVE_EN
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

    // Counts only cycles where the fabric could have gone but lost to the
    // core; a fabric stalled on its own outstanding read holds the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fab_win || !f_req_valid)
            starve_cnt_d = '0;
        else if (fab_elig && core_gnt && !starve_force)
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) starve_cnt_q <= '0;
        else        starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starve_force = 1'b0;
`endif

    assign fab_win     = fab_elig & (~core_req | starve_force);
    assign core_gnt    = core_req & ~fab_win;
    assign f_req_ready = fab_win;

    always_comb begin
        mem_address_b = '0;
        mem_data_b    = '0;
        mem_wren_b    = 1'b0;
        if (fab_win) begin
            mem_address_b = f_req_addr;
            mem_wren_b    = f_req_wr;
            mem_data_b    = f_req_wr ? f_req_data : 32'h0;
        end else if (core_gnt) begin
            mem_address_b = core_addr;
        end
    end

    // Ownership of the data that appears on mem_q_b next cycle.
    assign own_core_d = core_gnt;
    assign own_fab_d  = fab_win & ~f_req_wr;

    // Unaccepted bypass data is parked; a new read cannot be granted while
    // own_fab_q is set, so hold and bypass never overlap.
    always_comb begin
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        if (own_fab_q && !f_rsp_ready) begin
            hold_v_d = 1'b1;
            hold_d   = mem_q_b;
        end else if (hold_v_q && f_rsp_ready) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            own_core_q <= 1'b0;
            own_fab_q  <= 1'b0;
            hold_v_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            own_core_q <= own_core_d;
            own_fab_q  <= own_fab_d;
            hold_v_q   <= hold_v_d;
            hold_q     <= hold_d;
        end
    end

    assign core_rsp_valid = own_core_q;
    assign core_rsp_data  = own_core_q ? mem_q_b : 32'h0;
    assign f_rsp_valid    = own_fab_q | hold_v_q;
    assign f_rsp_data     = hold_v_q  ? hold_q  :
                            own_fab_q ? mem_q_b : 32'h0;

endmodule

// File: tb/tb_i_mem_b_arbiter.sv
module tb_i_mem_b_arbiter;
    localparam int LIM = 4;
`ifdef I_MEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0;
    logic [29:0] core_addr = '0;
    logic        core_gnt, core_rsp_valid;
    logic [31:0] core_rsp_data;
    logic        f_req_valid = 1'b0, f_req_wr = 1'b0, f_rsp_ready = 1'b0;
    logic [29:0] f_req_addr = '0;
    logic [31:0] f_req_data = '0;
    logic        f_req_ready, f_rsp_valid, mem_wren_b;
    logic [31:0] f_rsp_data, mem_data_b;
    logic [29:0] mem_address_b;
    logic [31:0] mem_q_b = '0;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    i_mem_b_arbiter #(.STARVE_LIMIT(LIM), .STARVE_W(8)) dut (
        .clock(clock), .rst_n(rst_n),
        .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_wr(f_req_wr),
        .f_req_addr(f_req_addr), .f_req_data(f_req_data),
        .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
        .mem_address_b(mem_address_b), .mem_data_b(mem_data_b),
        .mem_wren_b(mem_wren_b), .mem_q_b(mem_q_b)
    );

    // Synchronous memory behind port B (256 words is enough for the test).
    logic [31:0] mem [0:255];
    always @(posedge clock) begin
        if (mem_wren_b) mem[mem_address_b[7:0]] <= mem_data_b;
        mem_q_b <= mem[mem_address_b[7:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] ref_mem [0:255];
    logic [31:0] cq[$];
    logic [31:0] fq[$];
    int m_cnt = 0;

    always @(negedge clock) begin
        bit fel, frc, fw, cg, e_crv, e_frv, e_wren;
        logic [29:0] e_addr;
        logic [31:0] e_data, e_crd, e_frd;
        if (!rst_n) begin
            chk("mdl rst core_gnt", {31'b0, core_gnt}, 0);
            chk("mdl rst f_req_ready", {31'b0, f_req_ready}, 0);
            chk("mdl rst core_rsp_valid", {31'b0, core_rsp_valid}, 0);
            chk("mdl rst f_rsp_valid", {31'b0, f_rsp_valid}, 0);
            chk("mdl rst f_rsp_data", f_rsp_data, 0);
            chk("mdl rst mem_wren_b", {31'b0, mem_wren_b}, 0);
            cq.delete();
            fq.delete();
            m_cnt = 0;
        end else begin
            fel = f_req_valid && (f_req_wr || fq.size() == 0);
            frc = STARVE_EN && (m_cnt == LIM);
            fw  = fel && (!core_req || frc);
            cg  = core_req && !fw;
            e_addr = fw ? f_req_addr : (cg ? core_addr : 30'h0);
            e_wren = fw && f_req_wr;
            e_data = e_wren ? f_req_data : 32'h0;
            e_crv  = cq.size() != 0;
            e_crd  = e_crv ? cq[0] : 32'h0;
            e_frv  = fq.size() != 0;
            e_frd  = e_frv ? fq[0] : 32'h0;
            chk("mdl core_gnt", {31'b0, core_gnt}, {31'b0, cg});
            chk("mdl f_req_ready", {31'b0, f_req_ready}, {31'b0, fw});
            chk("mdl mem_address_b", {2'b0, mem_address_b}, {2'b0, e_addr});
            chk("mdl mem_wren_b", {31'b0, mem_wren_b}, {31'b0, e_wren});
            chk("mdl mem_data_b", mem_data_b, e_data);
            chk("mdl core_rsp_valid", {31'b0, core_rsp_valid}, {31'b0, e_crv});
            chk("mdl core_rsp_data", core_rsp_data, e_crd);
            chk("mdl f_rsp_valid", {31'b0, f_rsp_valid}, {31'b0, e_frv});
            chk("mdl f_rsp_data", f_rsp_data, e_frd);
            // end-of-cycle effects
            cq.delete();
            if (cg) cq.push_back(ref_mem[core_addr[7:0]]);
            if (e_frv && f_rsp_ready) void'(fq.pop_front());
            if (fw && !f_req_wr) fq.push_back(ref_mem[f_req_addr[7:0]]);
            if (fw && f_req_wr) ref_mem[f_req_addr[7:0]] = f_req_data;
            if (fw || !f_req_valid) m_cnt = 0;
            else if (fel && cg && m_cnt < LIM) m_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic smp(); @(negedge clock); endtask
    task automatic nxt(); @(posedge clock); #1; endtask

    task automatic setw(input int a, input logic [31:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int gc1, gc2;
        for (int i = 0; i < 256; i++) setw(i, 32'h1000 + i);
        setw(8'h00, 32'h99);
        setw(8'h10, 32'hA0);
        setw(8'h11, 32'hA1);
        setw(8'h12, 32'hA2);
        setw(8'h30, 32'h55);
        setw(8'h31, 32'h66);

        // reset state
        repeat (2) @(posedge clock);
        smp();
        chk("rst core_gnt", {31'b0, core_gnt}, 0);
        chk("rst f_req_ready", {31'b0, f_req_ready}, 0);
        chk("rst core_rsp_valid", {31'b0, core_rsp_valid}, 0);
        chk("rst f_rsp_valid", {31'b0, f_rsp_valid}, 0);
        chk("rst mem_wren_b", {31'b0, mem_wren_b}, 0);
        chk("rst mem_address_b", {2'b0, mem_address_b}, 0);
        chk("rst mem_data_b", mem_data_b, 0);
        chk("rst core_rsp_data", core_rsp_data, 0);
        chk("rst f_rsp_data", f_rsp_data, 0);
        nxt();
        rst_n = 1'b1;
        nxt();

        // back-to-back core reads
        core_req = 1'b1; core_addr = 30'h10;
        smp(); chk("t1 gnt0", {31'b0, core_gnt}, 1); nxt();
        core_addr = 30'h11;
        smp(); chk("t1 gnt1", {31'b0, core_gnt}, 1);
        chk("t1 rv0", {31'b0, core_rsp_valid}, 1); chk("t1 rd0", core_rsp_data, 32'hA0); nxt();
        core_addr = 30'h12;
        smp(); chk("t1 gnt2", {31'b0, core_gnt}, 1); chk("t1 rd1", core_rsp_data, 32'hA1); nxt();
        core_req = 1'b0; core_addr = '0;
        smp(); chk("t1 rv2", {31'b0, core_rsp_valid}, 1); chk("t1 rd2", core_rsp_data, 32'hA2); nxt();
        smp(); chk("t1 rv idle", {31'b0, core_rsp_valid}, 0); nxt();

        // fabric write then read-back
        f_rsp_ready = 1'b1;
        f_req_valid = 1'b1; f_req_wr = 1'b1; f_req_addr = 30'h20; f_req_data = 32'hDEADBEEF;
        smp(); chk("t2 wr ready", {31'b0, f_req_ready}, 1); chk("t2 wren", {31'b0, mem_wren_b}, 1);
        chk("t2 wdata", mem_data_b, 32'hDEADBEEF); chk("t2 waddr", {2'b0, mem_address_b}, 32'h20); nxt();
        f_req_wr = 1'b0; f_req_data = '0;
        smp(); chk("t2 rd ready", {31'b0, f_req_ready}, 1); chk("t2 rd wren", {31'b0, mem_wren_b}, 0); nxt();
        f_req_valid = 1'b0;
        smp(); chk("t2 rsp valid", {31'b0, f_rsp_valid}, 1); chk("t2 rsp data", f_rsp_data, 32'hDEADBEEF); nxt();
        smp(); chk("t2 rsp done", {31'b0, f_rsp_valid}, 0); nxt();

        // fabric response held under backpressure
        f_rsp_ready = 1'b0;
        f_req_valid = 1'b1; f_req_wr = 1'b0; f_req_addr = 30'h30;
        smp(); chk("t3 grant", {31'b0, f_req_ready}, 1); nxt();
        f_req_addr = 30'h31;
        for (int k = 1; k <= 3; k++) begin
            smp();
            chk("t3 held valid", {31'b0, f_rsp_valid}, 1);
            chk("t3 held data", f_rsp_data, 32'h55);
            chk("t3 no 2nd grant", {31'b0, f_req_ready}, 0);
            nxt();
        end
        f_rsp_ready = 1'b1;
        smp(); chk("t3 accept data", f_rsp_data, 32'h55); chk("t3 accept no grant", {31'b0, f_req_ready}, 0); nxt();
        smp(); chk("t3 2nd grant", {31'b0, f_req_ready}, 1); chk("t3 idle rsp", {31'b0, f_rsp_valid}, 0); nxt();
        f_req_valid = 1'b0;
        smp(); chk("t3 2nd data", f_rsp_data, 32'h66); nxt();
        smp(); nxt();

        // simultaneous requests and starvation
        core_req = 1'b1; core_addr = 30'h10;
        f_req_valid = 1'b1; f_req_wr = 1'b0; f_req_addr = 30'h31;
        gc1 = 0; gc2 = 0;
        for (int k = 1; k <= 12; k++) begin
            smp();
            if (k == 1) begin
                chk("t4 both core wins", {31'b0, core_gnt}, 1);
                chk("t4 both fab blocked", {31'b0, f_req_ready}, 0);
            end
            if (f_req_ready) begin
                chk("t4 core blocked on force", {31'b0, core_gnt}, 0);
                if (gc1 == 0) gc1 = k;
                else if (gc2 == 0) gc2 = k;
            end
            nxt();
        end
        chk("t4 first fab grant cycle", gc1, STARVE_EN ? 5 : 0);
        chk("t4 second fab grant cycle", gc2, STARVE_EN ? 11 : 0);
        core_req = 1'b0; f_req_valid = 1'b0; core_addr = '0;
        repeat (3) begin smp(); nxt(); end

        // reset right after a fabric read grant
        f_rsp_ready = 1'b0;
        f_req_valid = 1'b1; f_req_wr = 1'b0; f_req_addr = 30'h30;
        smp(); chk("t5 grant", {31'b0, f_req_ready}, 1); nxt();
        f_req_valid = 1'b0;
        chk("t5 rsp before rst", {31'b0, f_rsp_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("t5 rsp dropped", {31'b0, f_rsp_valid}, 0);
        chk("t5 data dropped", f_rsp_data, 0);
        smp(); nxt();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp(); chk("t5 no rsp after release", {31'b0, f_rsp_valid}, 0); nxt();
        end
        f_rsp_ready = 1'b1;
        smp(); nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i_mem_b_arbiter.md
# i_mem_b_arbiter

Shares port B of the big-core instruction memory between the core fetch path and the fabric/loader path. Each cycle it grants one requester, drives the memory address, write-data and write-enable, and tracks the memory's 1-cycle synchronous read latency. It routes read data back to whichever requester owns it, and holds fabric read responses until they are accepted. It sits directly between the fetch stage / fabric interface and the memory's `address_b`/`data_b`/`wren_b`/`q_b` pins.

## Interface
- STARVE_LIMIT, 8: consecutive core-blocked cycles before the fabric is forced a grant (range 1..255).
- STARVE_W, 8: width of the starvation counter.
- clock  in  1  single clock, all state rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- core_req  in  1  core read request (fetch).
- core_addr  in  30  core word address [31:2].
- core_gnt  out  1  core request accepted this cycle.
- core_rsp_valid  out  1  core read data valid.
- core_rsp_data  out  32  core read data.
- f_req_valid  in  1  fabric request valid.
- f_req_ready  out  1  fabric request accepted this cycle.
- f_req_wr  in  1  1 = write, 0 = read.
- f_req_addr  in  30  fabric word address [31:2].
- f_req_data  in  32  fabric write data.
- f_rsp_valid  out  1  fabric read response valid.
- f_rsp_ready  in  1  fabric accepts response.
- f_rsp_data  out  32  fabric read data.
- mem_address_b  out  30  to memory `address_b`.
- mem_data_b  out  32  to memory `data_b`.
- mem_wren_b  out  1  to memory `wren_b`.
- mem_q_b  in  32  from memory `q_b`, valid 1 cycle after address.

## Operation
- Eligibility:
  - The core is eligible when `core_req` is high.
  - The fabric is eligible when `f_req_valid` is high and either the request is a write, or it is a read with no fabric read in flight and the hold register empty.
- Arbitration (combinational, same cycle): the core wins by default. The fabric wins if it is the only eligible requester, or if `starve_force` is set.
  - `starve_force` means starve_cnt == STARVE_LIMIT.
  - `core_gnt` and `f_req_ready` are never both 1.
- Memory drive:
  - Winner's address goes to `mem_address_b`.
  - `mem_wren_b` = fabric granted AND `f_req_wr`.
  - `mem_data_b` = `f_req_data` when a fabric write is granted, else 0.
  - With no grant: address 0, wren 0.
- Owner pipeline register, cleared by reset: `own_core` is set for the cycle after a core grant. `own_fab` is set for the cycle after a fabric read grant. Fabric writes set neither.
- Core response: `core_rsp_valid` = `own_core`, `core_rsp_data` = `mem_q_b`. There is no backpressure.
- Fabric response:
  - While `own_fab` is set: `f_rsp_valid` = 1 and `f_rsp_data` = `mem_q_b` (bypass).
  - If `f_rsp_ready` = 0, `mem_q_b` is captured into the hold register and `hold_v` is set.
  - While `hold_v` is set: `f_rsp_valid` = 1, data comes from the hold register, and `hold_v` clears on `f_rsp_ready`.
  - At most one fabric read is outstanding.
- Starvation counter:
  - Increments when the fabric is eligible but the core is granted.
  - Clears on any fabric grant, or when `f_req_valid` = 0.
  - Saturates at STARVE_LIMIT.
  - Does not count while the fabric is ineligible because of an outstanding read.

## Timing
- Reset values: `core_gnt`, `f_req_ready`, `core_rsp_valid`, `f_rsp_valid`, `mem_wren_b` = 0; `mem_address_b`, `mem_data_b`, `core_rsp_data`, `f_rsp_data` = 0; starve_cnt = 0; `hold_v` = 0.
- Grant to read data: exactly 1 cycle. Request granted in cycle T gives response in T+1.
- Writes commit at the clock edge ending the grant cycle.
- A read at T+1 to an address written at T returns the new data.
- Back-to-back core reads give one response per cycle.
- Fabric read throughput is one per 2 cycles at best, because no new read is granted while `own_fab` is set.
- Reset asserted mid-operation: owner bits, hold register and counter clear immediately (async). In-flight responses are dropped and no response is emitted after reset release.

## Configuration
- `I_MEM_ARB_STARVE_EN`:
  - Defined: starvation counter and forced fabric grant are present as described.
  - Undefined: strict core priority, and the counter logic is removed. The fabric is granted only in cycles with `core_req` = 0.

## Test plan
- Core reads addr 0x10, 0x11, 0x12 on consecutive cycles (mem preloaded 0xA0,0xA1,0xA2) -> `core_gnt` = 1 each cycle; `core_rsp_valid` cycles 1–3 with data 0xA0,0xA1,0xA2.
- Fabric write addr 0x20 data 0xDEADBEEF, then fabric read 0x20 with `f_rsp_ready` = 1 -> `mem_wren_b` = 1 for one cycle; `f_rsp_valid` one cycle after the read grant with 0xDEADBEEF.
- Fabric read with `f_rsp_ready` held 0 for 3 cycles while `mem_q_b` changes -> `f_rsp_data` stable at the first value; second fabric read not granted (`f_req_ready` = 0) until 1 cycle after acceptance.
- `core_req` continuously high, fabric read pending, STARVE_LIMIT = 4, macro defined -> core granted 4 cycles, fabric granted cycle 5 with `core_gnt` = 0, counter back to 0. Macro undefined -> fabric never granted.
- Simultaneous core and fabric requests with `I_MEM_ARB_STARVE_EN` defined and counter below limit -> only `core_gnt` = 1; `f_req_ready` = 0.
- `rst_n` pulled low the cycle after a fabric read grant -> `f_rsp_valid` = 0 immediately and stays 0 after release; `hold_v` = 0.
